// File: rtl/slink_clk_switch_ctrl.sv
// rtl/slink_clk_switch_ctrl.sv - refclk-domain sequencer for the link clock glitch-free mux select
module slink_clk_switch_ctrl #(
  parameter int WINDOW_CYC  = 64,
  parameter int MIN_TOGGLES = 4,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       switch_req,
  input  logic       phy_clk_toggle,
  input  logic       lost_clr,
  output logic       use_phy_clk,
  output logic       switch_done,
  output logic       phy_clk_lost,
  output logic       phy_clk_lost_sts,
  output logic [2:0] state
);

  // One counter width fits every parameter; counters clear on state entry so none can wrap.
  localparam int MAX_AB = (WINDOW_CYC > MIN_TOGGLES) ? WINDOW_CYC : MIN_TOGGLES;
  localparam int MAX_CD = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] WIN_LAST    = CW'(WINDOW_CYC - 1);
  localparam logic [CW-1:0] TGL_MIN     = CW'(MIN_TOGGLES);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] WD_LAST     = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] ONE         = CW'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    SWITCH = 3'd2,
    ON     = 3'd3,
    BACK   = 3'd4
  } state_t;

  state_t        st;
  logic          sync1;
  logic          sync2;
  logic          sync3;
  logic          tgl_pulse;
  logic [CW-1:0] win_cnt;
  logic [CW-1:0] tgl_cnt;
  logic [CW-1:0] tgl_next;
  logic [CW-1:0] settle_cnt;
  logic [CW-1:0] wd_cnt;

  assign state = st;

  // Bring the phy_clk-domain toggle into refclk and keep one delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= phy_clk_toggle;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign tgl_pulse = sync2 ^ sync3;

  // Toggle count including a pulse arriving this cycle, saturating at the qualify threshold.
  always_comb begin
    tgl_next = tgl_cnt;
    if (tgl_pulse && (tgl_cnt < TGL_MIN)) begin
      tgl_next = tgl_cnt + ONE;
    end
  end

  // Sequencer: qualify, switch, watch, fall back; all outputs are registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st               <= IDLE;
      win_cnt          <= '0;
      tgl_cnt          <= '0;
      settle_cnt       <= '0;
      wd_cnt           <= '0;
      use_phy_clk      <= 1'b0;
      switch_done      <= 1'b0;
      phy_clk_lost     <= 1'b0;
      phy_clk_lost_sts <= 1'b0;
    end else begin
      phy_clk_lost <= 1'b0;
      // A loss detected below in the same cycle overrides this clear.
      if (lost_clr) begin
        phy_clk_lost_sts <= 1'b0;
      end

      case (st)
        IDLE: begin
          if (switch_req && !phy_clk_lost_sts) begin
            st      <= CHECK;
            win_cnt <= '0;
            tgl_cnt <= '0;
          end
        end

        CHECK: begin
          if (!switch_req) begin
            st <= IDLE;
          end else if (win_cnt == WIN_LAST) begin
            if (tgl_next >= TGL_MIN) begin
              st          <= SWITCH;
              use_phy_clk <= 1'b1;
              settle_cnt  <= '0;
            end else begin
              win_cnt <= '0;
              tgl_cnt <= '0;
            end
          end else begin
            win_cnt <= win_cnt + ONE;
            tgl_cnt <= tgl_next;
          end
        end

        // Request changes are not honoured until the mux has settled on phy_clk.
        SWITCH: begin
          if (settle_cnt == SETTLE_LAST) begin
            st          <= ON;
            switch_done <= 1'b1;
            wd_cnt      <= '0;
          end else begin
            settle_cnt <= settle_cnt + ONE;
          end
        end

        ON: begin
          if (!tgl_pulse && (wd_cnt == WD_LAST)) begin
            st               <= BACK;
            use_phy_clk      <= 1'b0;
            switch_done      <= 1'b0;
            settle_cnt       <= '0;
            phy_clk_lost     <= 1'b1;
            phy_clk_lost_sts <= 1'b1;
          end else begin
            wd_cnt <= tgl_pulse ? '0 : (wd_cnt + ONE);
            if (!switch_req) begin
              st          <= BACK;
              use_phy_clk <= 1'b0;
              switch_done <= 1'b0;
              settle_cnt  <= '0;
            end
          end
        end

        // Hold on refclk for a full settle period regardless of the request.
        BACK: begin
          if (settle_cnt == SETTLE_LAST) begin
            st <= IDLE;
          end else begin
            settle_cnt <= settle_cnt + ONE;
          end
        end

        default: begin
          st          <= IDLE;
          use_phy_clk <= 1'b0;
          switch_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slink_clk_switch_ctrl.sv
// tb/tb_slink_clk_switch_ctrl.sv - directed self-checking bench for slink_clk_switch_ctrl
module tb_slink_clk_switch_ctrl;

  logic       clk;
  logic       reset_n;
  logic       switch_req;
  logic       lost_clr;
  logic       gen_tgl;
  logic       man_tgl;
  logic       use_phy_clk;
  logic       switch_done;
  logic       phy_clk_lost;
  logic       phy_clk_lost_sts;
  logic [2:0] state;

  int checks;
  int errors;
  int tgl_period;
  int gen_cnt;

  slink_clk_switch_ctrl dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .switch_req       (switch_req),
    .phy_clk_toggle   (gen_tgl ^ man_tgl),
    .lost_clr         (lost_clr),
    .use_phy_clk      (use_phy_clk),
    .switch_done      (switch_done),
    .phy_clk_lost     (phy_clk_lost),
    .phy_clk_lost_sts (phy_clk_lost_sts),
    .state            (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running phy_clk toggle source; period 0 freezes it.
  initial begin
    gen_tgl = 1'b0;
    gen_cnt = 0;
    forever begin
      @(negedge clk);
      if (tgl_period != 0) begin
        gen_cnt = gen_cnt + 1;
        if (gen_cnt >= tgl_period) begin
          gen_cnt = 0;
          gen_tgl = ~gen_tgl;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int bound, input string tag);
    int n;
    n = 0;
    while ((state !== s) && (n < bound)) begin
      tick();
      n = n + 1;
    end
    check(tag, {29'd0, state}, {29'd0, s});
  endtask

  task automatic stall_and_kick();
    tgl_period = 0;
    repeat (4) tick();
    man_tgl = ~man_tgl;
    repeat (34) tick();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    tgl_period = 4;
    reset_n    = 1'b0;
    switch_req = 1'b0;
    lost_clr   = 1'b0;
    man_tgl    = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_use", use_phy_clk, 1'b0);
    check("rst_done", switch_done, 1'b0);
    check("rst_lost", phy_clk_lost, 1'b0);
    check("rst_sts", phy_clk_lost_sts, 1'b0);
    check("rst_state", state, 3'd0);
    reset_n = 1'b1;
    tick();

    // 1: fast toggling qualifies at the end of the first window
    switch_req = 1'b1;
    tick();
    check("t1_check", state, 3'd1);
    repeat (63) tick();
    check("t1_use_early", use_phy_clk, 1'b0);
    check("t1_state_early", state, 3'd1);
    tick();
    check("t1_use", use_phy_clk, 1'b1);
    check("t1_switch", state, 3'd2);
    repeat (15) tick();
    check("t1_done_early", switch_done, 1'b0);
    tick();
    check("t1_done", switch_done, 1'b1);
    check("t1_on", state, 3'd3);

    // 3: clock loss while selected
    stall_and_kick();
    check("t3_lost_early", phy_clk_lost, 1'b0);
    check("t3_on_early", state, 3'd3);
    tick();
    check("t3_lost", phy_clk_lost, 1'b1);
    check("t3_back", state, 3'd4);
    check("t3_use", use_phy_clk, 1'b0);
    check("t3_done", switch_done, 1'b0);
    check("t3_sts", phy_clk_lost_sts, 1'b1);
    tick();
    check("t3_lost_width", phy_clk_lost, 1'b0);
    repeat (14) tick();
    check("t3_back_hold", state, 3'd4);
    tick();
    check("t3_idle", state, 3'd0);
    repeat (3) tick();
    check("t3_no_retry", state, 3'd0);
    tgl_period = 4;
    lost_clr = 1'b1;
    tick();
    lost_clr = 1'b0;
    check("t3_sts_clr", phy_clk_lost_sts, 1'b0);
    check("t3_idle_clr", state, 3'd0);
    tick();
    check("t3_retry", state, 3'd1);

    // 4: request drop while ON, request raised again during BACK
    wait_state(3'd3, 300, "t4_reach_on");
    switch_req = 1'b0;
    tick();
    check("t4_back", state, 3'd4);
    check("t4_use", use_phy_clk, 1'b0);
    check("t4_done", switch_done, 1'b0);
    check("t4_no_lost", phy_clk_lost_sts, 1'b0);
    switch_req = 1'b1;
    repeat (15) tick();
    check("t4_back_ignore", state, 3'd4);
    tick();
    check("t4_idle", state, 3'd0);
    tick();
    check("t4_recheck", state, 3'd1);

    // 2: too few toggles per window keeps the sequencer in CHECK
    switch_req = 1'b0;
    tick();
    check("t2_idle", state, 3'd0);
    tgl_period = 22;
    repeat (5) tick();
    switch_req = 1'b1;
    repeat (3 * 64 + 2) tick();
    check("t2_stay_check", state, 3'd1);
    check("t2_use", use_phy_clk, 1'b0);
    tgl_period = 4;
    wait_state(3'd2, 200, "t2_switch");
    check("t2_use_on", use_phy_clk, 1'b1);
    wait_state(3'd3, 40, "t2_on");

    // 5a: timeout and request drop in the same cycle
    stall_and_kick();
    switch_req = 1'b0;
    tick();
    check("t5a_lost", phy_clk_lost, 1'b1);
    check("t5a_back", state, 3'd4);
    check("t5a_sts", phy_clk_lost_sts, 1'b1);
    switch_req = 1'b1;
    wait_state(3'd0, 20, "t5a_idle");
    lost_clr = 1'b1;
    tick();
    lost_clr = 1'b0;
    check("t5a_clr", phy_clk_lost_sts, 1'b0);
    tgl_period = 4;
    wait_state(3'd3, 300, "t5b_reach_on");

    // 5b: lost_clr coincident with a new loss
    stall_and_kick();
    lost_clr = 1'b1;
    tick();
    lost_clr = 1'b0;
    check("t5b_lost", phy_clk_lost, 1'b1);
    check("t5b_sts_set_wins", phy_clk_lost_sts, 1'b1);
    wait_state(3'd0, 20, "t5b_idle");
    tick();
    check("t5b_no_retry", state, 3'd0);

    // 5c: request drop exactly at window end
    tgl_period = 4;
    lost_clr = 1'b1;
    tick();
    lost_clr = 1'b0;
    check("t5c_clr", phy_clk_lost_sts, 1'b0);
    tick();
    check("t5c_check", state, 3'd1);
    repeat (63) tick();
    check("t5c_last", state, 3'd1);
    switch_req = 1'b0;
    tick();
    check("t5c_idle", state, 3'd0);
    check("t5c_use", use_phy_clk, 1'b0);

    // 6: asynchronous reset mid-SWITCH and mid-ON
    switch_req = 1'b1;
    wait_state(3'd2, 300, "t6_reach_switch");
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    check("t6_sw_use", use_phy_clk, 1'b0);
    check("t6_sw_state", state, 3'd0);
    tick();
    reset_n = 1'b1;
    wait_state(3'd3, 300, "t6_reach_on");
    repeat (2) tick();
    reset_n = 1'b0;
    #1;
    check("t6_on_use", use_phy_clk, 1'b0);
    check("t6_on_done", switch_done, 1'b0);
    check("t6_on_state", state, 3'd0);
    tick();
    reset_n = 1'b1;
    wait_state(3'd2, 300, "t6_resume_switch");
    check("t6_resume_use", use_phy_clk, 1'b1);
    wait_state(3'd3, 40, "t6_resume_on");
    check("t6_resume_done", switch_done, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
